dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding byte/word load/store with programmable wait states.
// Optional word-alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              load,
   input  logic              size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              lat_load;
   logic              lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [7:0]        mem [2**ADDR_W];

   logic              acc_load;
   logic              acc_size;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       acc_wdata;
   logic [ADDR_W-1:0] addr_p1;
   logic [ADDR_W-1:0] addr_p2;
   logic [ADDR_W-1:0] addr_p3;
   logic              commit;
   logic              misaligned;
   logic [31:0]       rd_value;

   assign busy = (state != IDLE);

   // With zero wait states the access commits on the accepting edge, so the
   // live request fields are used instead of the not-yet-latched copies.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      acc_load  = lat_load;
      acc_size  = lat_size;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      if (state == IDLE) begin
         acc_load  = load;
         acc_size  = size;
         acc_addr  = addr;
         acc_wdata = wdata;
      end
      addr_p1 = acc_addr + ADDR_W'(1);
      addr_p2 = acc_addr + ADDR_W'(2);
      addr_p3 = acc_addr + ADDR_W'(3);
      commit  = ((state == WAIT) && (cnt == 4'd0)) ||
                ((state == IDLE) && req && (WAIT_CYCLES == 0));
`ifdef DMEM_ALIGN_CHECK_EN
      misaligned = acc_size && (acc_addr[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
      rd_value = acc_size ? {mem[acc_addr], mem[addr_p1], mem[addr_p2], mem[addr_p3]}
                          : {24'h0, mem[acc_addr]};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'h0;
      end else begin
         ready <= commit;
         err   <= commit & misaligned;
         if (commit && acc_load)
            rdata <= misaligned ? 32'h0 : rd_value;
         case (state)
            IDLE: begin
               if (req) begin
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0)
                  state <= RESP;
               else
                  cnt <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Request capture is pure datapath; it only matters once the FSM leaves IDLE.
   always_ff @(posedge clk) begin
      if (state == IDLE && req) begin
         lat_load  <= load;
         lat_size  <= size;
         lat_addr  <= addr;
         lat_wdata <= wdata;
      end
   end

   // NOTE: the array has no reset; its contents survive reset by design.
   always_ff @(posedge clk) begin
      if (!reset && commit && !acc_load && !misaligned) begin
         if (acc_size) begin
            mem[acc_addr] <= acc_wdata[31:24];
            mem[addr_p1]  <= acc_wdata[23:16];
            mem[addr_p2]  <= acc_wdata[15:8];
            mem[addr_p3]  <= acc_wdata[7:0];
         end else begin
            mem[acc_addr] <= acc_wdata[7:0];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (0, 1 and 3 wait states)
// share one stimulus stream and are compared every cycle against a transaction-level model.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   localparam int NI = 3;

   logic        clk;
   logic        reset;
   logic        req;
   logic        load;
   logic        size;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [NI-1:0] busy_v;
   logic [NI-1:0] ready_v;
   logic [NI-1:0] err_v;
   logic [31:0]   rdata_v [NI];

   int n_cmp  = 0;
   int n_fail = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
         .ADDR_W      (8),
         .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .req   (req),
         .load  (load),
         .size  (size),
         .addr  (addr),
         .wdata (wdata),
         .busy  (busy_v[g]),
         .ready (ready_v[g]),
         .rdata (rdata_v[g]),
         .err   (err_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0]  mm [NI][256];
   int          rem [NI];
   logic        t_load [NI];
   logic        t_size [NI];
   int          t_addr [NI];
   logic [31:0] t_wdata [NI];
   logic        e_ready [NI];
   logic        e_err [NI];
   logic [31:0] e_rdata [NI];
   bit          started = 1'b0;

   function automatic int wc_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
   endfunction

   task automatic do_access(input int i);
      int  a;
      bit  mis;
      a   = t_addr[i];
      mis = ALIGN && t_size[i] && (a % 4 != 0);
      e_err[i] = mis;
      if (t_load[i]) begin
         if (mis)
            e_rdata[i] = 32'h0;
         else if (t_size[i])
            e_rdata[i] = {mm[i][a], mm[i][(a + 1) % 256], mm[i][(a + 2) % 256], mm[i][(a + 3) % 256]};
         else
            e_rdata[i] = {24'h0, mm[i][a]};
      end else if (!mis) begin
         if (t_size[i]) begin
            mm[i][a]             = t_wdata[i][31:24];
            mm[i][(a + 1) % 256] = t_wdata[i][23:16];
            mm[i][(a + 2) % 256] = t_wdata[i][15:8];
            mm[i][(a + 3) % 256] = t_wdata[i][7:0];
         end else begin
            mm[i][a] = t_wdata[i][7:0];
         end
      end
   endtask

   // rem counts the busy cycles left; an access takes WC+1 busy cycles, the last one answering.
   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         if (reset) begin
            rem[i]     = 0;
            e_ready[i] = 1'b0;
            e_err[i]   = 1'b0;
            e_rdata[i] = 32'h0;
         end else begin
            e_ready[i] = 1'b0;
            e_err[i]   = 1'b0;
            if (rem[i] > 0) begin
               rem[i]--;
            end else if (req) begin
               t_load[i]  = load;
               t_size[i]  = size;
               t_addr[i]  = int'(addr);
               t_wdata[i] = wdata;
               rem[i]     = wc_of(i) + 1;
            end
            if (rem[i] == 1) begin
               e_ready[i] = 1'b1;
               do_access(i);
            end
         end
      end
      if (reset) started = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rem[i] = 0;
         for (int b = 0; b < 256; b++) mm[i][b] = 8'h0;
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            for (int i = 0; i < NI; i++) begin
               check($sformatf("busy[%0d]", i),  32'(busy_v[i]),  32'(rem[i] > 0));
               check($sformatf("ready[%0d]", i), 32'(ready_v[i]), 32'(e_ready[i]));
               check($sformatf("err[%0d]", i),   32'(err_v[i]),   32'(e_err[i]));
               check($sformatf("rdata[%0d]", i), rdata_v[i],      e_rdata[i]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input logic l, input logic s, input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; load = l; size = s; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic rand_fields();
      load  = 1'($urandom_range(0, 1));
      size  = 1'($urandom_range(0, 1));
      addr  = 8'($urandom_range(0, 255));
      wdata = $urandom;
   endtask

   task automatic check_all_rdata(input string name, input logic [31:0] exp);
      for (int i = 0; i < NI; i++)
         check($sformatf("%s[%0d]", name, i), rdata_v[i], exp);
   endtask

   initial begin
      int rcnt [NI];
      int mode;
      int dly;
      logic [31:0] old_20;

      reset = 1'b1; req = 1'b0; load = 1'b0; size = 1'b0; addr = 8'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_busy[%0d]", i),  32'(busy_v[i]),  32'h0);
         check($sformatf("rst_ready[%0d]", i), 32'(ready_v[i]), 32'h0);
         check($sformatf("rst_rdata[%0d]", i), rdata_v[i],      32'h0);
         check($sformatf("rst_err[%0d]", i),   32'(err_v[i]),   32'h0);
      end
      reset = 1'b0;

      // Fill the whole array so every later read has a defined value.
      for (int k = 0; k < 64; k++) txn(1'b0, 1'b1, 8'(4 * k), $urandom);

      // Basic word/byte access and byte merge.
      txn(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
      txn(1'b1, 1'b1, 8'h10, 32'h0);
      check_all_rdata("word_rd_10", 32'hDEADBEEF);
      txn(1'b1, 1'b0, 8'h11, 32'h0);
      check_all_rdata("byte_rd_11", 32'h000000AD);
      txn(1'b0, 1'b0, 8'h12, 32'h00000055);
      txn(1'b1, 1'b1, 8'h10, 32'h0);
      check_all_rdata("merge_rd_10", 32'hDEAD55EF);

      // req held for 10 sampling edges with fresh random reads every cycle.
      for (int i = 0; i < NI; i++) rcnt[i] = 0;
      @(negedge clk);
      req = 1'b1; load = 1'b1; size = 1'($urandom_range(0, 1)); addr = 8'($urandom_range(0, 255));
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) rcnt[i] += int'(ready_v[i]);
         if (k < 9) begin
            size = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 255));
         end else begin
            req = 1'b0;
         end
      end
      check("burst_readys[0]", 32'(rcnt[0]), 32'd5);
      check("burst_readys[1]", 32'(rcnt[1]), 32'd4);
      check("burst_readys[2]", 32'(rcnt[2]), 32'd2);
      repeat (5) @(negedge clk);

      // Misaligned word write across the top of the array.
      txn(1'b0, 1'b1, 8'h00, 32'hA0B0C0D0);
      txn(1'b0, 1'b1, 8'hFC, 32'h01020304);
      txn(1'b0, 1'b1, 8'hFE, 32'h11223344);
      txn(1'b1, 1'b0, 8'hFE, 32'h0);
      check_all_rdata("wrap_rd_fe", ALIGN ? 32'h03 : 32'h11);
      txn(1'b1, 1'b0, 8'hFF, 32'h0);
      check_all_rdata("wrap_rd_ff", ALIGN ? 32'h04 : 32'h22);
      txn(1'b1, 1'b0, 8'h00, 32'h0);
      check_all_rdata("wrap_rd_00", ALIGN ? 32'hA0 : 32'h33);
      txn(1'b1, 1'b0, 8'h01, 32'h0);
      check_all_rdata("wrap_rd_01", ALIGN ? 32'hB0 : 32'h44);

      // Reset two edges after acceptance: aborts the 3-wait-state write only.
      old_20 = 32'hCAFEF00D;
      txn(1'b0, 1'b1, 8'h20, old_20);
      @(negedge clk);
      req = 1'b1; load = 1'b0; size = 1'b1; addr = 8'h20; wdata = 32'h12345678;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("abort_busy[%0d]", i),  32'(busy_v[i]),  32'h0);
         check($sformatf("abort_ready[%0d]", i), 32'(ready_v[i]), 32'h0);
      end
      repeat (2) @(negedge clk);
      txn(1'b1, 1'b1, 8'h20, 32'h0);
      check("abort_rd[0]", rdata_v[0], 32'h12345678);
      check("abort_rd[1]", rdata_v[1], 32'h12345678);
      check("abort_rd[2]", rdata_v[2], old_20);

      // Reset and req together: reset wins, nothing is accepted.
      @(negedge clk);
      reset = 1'b1; req = 1'b1; load = 1'b1; size = 1'b1; addr = 8'h10;
      @(negedge clk);
      reset = 1'b0; req = 1'b0;
      for (int i = 0; i < NI; i++) rcnt[i] = 0;
      repeat (6) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) rcnt[i] += int'(ready_v[i]);
      end
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rstreq_readys[%0d]", i), 32'(rcnt[i]), 32'h0);
         check($sformatf("rstreq_rdata[%0d]", i),  rdata_v[i],    32'h0);
         check($sformatf("rstreq_err[%0d]", i),    32'(err_v[i]), 32'h0);
      end

      // Randomized traffic: single requests, held-req bursts and mid-operation resets.
      for (int n = 0; n < 200; n++) begin
         mode = $urandom_range(0, 9);
         if (mode < 6) begin
            @(negedge clk);
            rand_fields();
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            repeat ($urandom_range(4, 6)) @(negedge clk);
         end else if (mode < 9) begin
            dly = $urandom_range(1, 6);
            for (int c = 0; c < dly; c++) begin
               @(negedge clk);
               rand_fields();
               req = 1'b1;
            end
            @(negedge clk);
            req = 1'b0;
            repeat (5) @(negedge clk);
         end else begin
            @(negedge clk);
            rand_fields();
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            reset = 1'b1;
            req   = 1'($urandom_range(0, 1));
            @(negedge clk);
            reset = 1'b0;
            req   = 1'b0;
            repeat (5) @(negedge clk);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
